// File: rtl/codes_pkg.sv
// Shared type and helper definitions for the CPU memory stage.
//   size_t     : 32-bit data/address word
//   memop_t    : load/store operation codes
//   memstate_t : state encoding of the load/store engine
// Helper functions classify operations and build store byte lanes.
package codes;

    typedef logic [31:0] size_t;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9
    } memop_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } memstate_t;

    function automatic logic is_load(input memop_t op);
        return (op != SB) && (op != SH) && (op != SW);
    endfunction

    // Byte accesses and the unaligned-word ops (LWL/LWR) can never fault.
    function automatic logic is_misaligned(input memop_t op, input logic [1:0] k);
        case (op)
            LH, LHU, SH: return k[0];
            LW, SW:      return (k != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_byteenable(input memop_t op, input logic [1:0] k);
        case (op)
            SB:      return 4'b0001 << k;
            SH:      return k[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the datum across every lane lets the byteenable alone
    // pick the destination, so no data shifter is needed.
    function automatic size_t store_lanes(input memop_t op, input size_t data);
        case (op)
            SB:      return {4{data[7:0]}};
            SH:      return {2{data[15:0]}};
            SW:      return data;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load aligner: extracts, sign/zero-extends or merges the
// returned memory word according to the load operation and byte offset.
// Ports:
//   op     : load operation
//   k      : byte offset within the word (addr[1:0])
//   w      : word returned by memory
//   rt_old : current rt value, merged for LWL/LWR
//   result : final 32-bit load value
module mem_load_align
    import codes::*;
(
    input  memop_t     op,
    input  logic [1:0] k,
    input  size_t      w,
    input  size_t      rt_old,
    output size_t      result
);

    logic [7:0]  w_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [4:0]  lwl_shift;
    logic [4:0]  lwr_shift;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign w_byte[gi] = w[8*gi +: 8];
    end

    assign sel_byte  = w_byte[k];
    assign sel_half  = k[1] ? w[31:16] : w[15:0];
    assign lwl_shift = {2'd3 - k, 3'b000};
    assign lwr_shift = {k, 3'b000};

    always_comb begin
        result = w;
        case (op)
            LB:  result = {{24{sel_byte[7]}}, sel_byte};
            LBU: result = {24'd0, sel_byte};
            LH:  result = {{16{sel_half[15]}}, sel_half};
            LHU: result = {16'd0, sel_half};
            LW:  result = w;
            // The rt mask is written as ~(ones << s) so k=3 yields an all-zero
            // mask without needing a 32-bit shift.
            LWL: result = (w << lwl_shift) | (rt_old & ~(32'hFFFF_FFFF << lwl_shift));
            LWR: result = (w >> lwr_shift) | (rt_old & ~(32'hFFFF_FFFF >> lwr_shift));
            default: result = w;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Avalon-MM master load/store engine for the CPU memory stage. Takes one
// command at a time, issues a single word-aligned read or write, and
// reports completion with a one-cycle done pulse.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start, op, addr    : command strobe, operation, byte address
//   store_data, rt_old : store value, old rt for LWL/LWR merge
//   busy, done, err    : engine busy, completion pulse, misaligned flag
//   load_result        : load value, held until the next load completes
//   av_*               : Avalon-MM master interface (all outputs registered)
module mem_access_unit
    import codes::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  memop_t     op,
    input  size_t      addr,
    input  size_t      store_data,
    input  size_t      rt_old,
    output logic       busy,
    output logic       done,
    output logic       err,
    output size_t      load_result,
    output size_t      av_address,
    output logic       av_read,
    output logic       av_write,
    output logic [3:0] av_byteenable,
    output size_t      av_writedata,
    input  size_t      av_readdata,
    input  logic       av_waitrequest
);

    memstate_t  state_reg;
    memop_t     op_reg;
    logic [1:0] k_reg;
    size_t      rt_old_reg;
    size_t      align_result;

    mem_load_align u_align (
        .op     (op_reg),
        .k      (k_reg),
        .w      (av_readdata),
        .rt_old (rt_old_reg),
        .result (align_result)
    );

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            op_reg        <= LB;
            k_reg         <= 2'b00;
            rt_old_reg    <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            load_result   <= '0;
            av_address    <= '0;
            av_read       <= 1'b0;
            av_write      <= 1'b0;
            av_byteenable <= 4'b0000;
            av_writedata  <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg     <= op;
                        k_reg      <= addr[1:0];
                        rt_old_reg <= rt_old;
                        if (is_misaligned(op, addr[1:0])) begin
                            // Fault completes immediately without touching the bus.
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            err           <= 1'b0;
                            state_reg     <= ISSUE;
                            av_address    <= {addr[31:2], 2'b00};
                            av_read       <= is_load(op);
                            av_write      <= !is_load(op);
                            av_byteenable <= store_byteenable(op, addr[1:0]);
                            av_writedata  <= store_lanes(op, store_data);
                        end
                    end
                end
                ISSUE: begin
                    // Request outputs stay frozen until the slave accepts.
                    if (!av_waitrequest) begin
                        av_read  <= 1'b0;
                        av_write <= 1'b0;
                        if (is_load(op_reg)) begin
                            state_reg <= CAPTURE;
                        end else begin
                            done      <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                end
                CAPTURE: begin
                    load_result <= align_result;
                    done        <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    av_read   <= 1'b0;
                    av_write  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by
// randomized load/store traffic against a byte-level reference model.
module tb_mem_access_unit;
    import codes::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    memop_t     op;
    size_t      addr;
    size_t      store_data;
    size_t      rt_old;
    logic       busy;
    logic       done;
    logic       err;
    size_t      load_result;
    size_t      av_address;
    logic       av_read;
    logic       av_write;
    logic [3:0] av_byteenable;
    size_t      av_writedata;
    size_t      av_readdata;
    logic       av_waitrequest;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_load = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .op             (op),
        .addr           (addr),
        .store_data     (store_data),
        .rt_old         (rt_old),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .load_result    (load_result),
        .av_address     (av_address),
        .av_read        (av_read),
        .av_write       (av_write),
        .av_byteenable  (av_byteenable),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest)
    );

    task automatic chk(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] byte_of(input logic [31:0] v, input int i);
        return v[8*i +: 8];
    endfunction

    function automatic logic model_is_load(input memop_t o);
        return !(o == SB || o == SH || o == SW);
    endfunction

    function automatic logic model_misaligned(input memop_t o, input logic [31:0] a);
        if (o == LH || o == LHU || o == SH) return (a % 2) != 0;
        if (o == LW || o == SW)             return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input memop_t o, input logic [31:0] a);
        int k = int'(a % 4);
        if (o == SB) return 4'(1 << k);
        if (o == SH) return (k >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wd(input memop_t o, input logic [31:0] d);
        if (o == SB) return (d % 256) * 32'h0101_0101;
        if (o == SH) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input memop_t o, input logic [31:0] a,
                                               input logic [31:0] w, input logic [31:0] rt);
        int k = int'(a % 4);
        int h = k / 2;
        int v;
        logic [31:0] r = 32'h0;
        case (o)
            LB: begin
                v = int'(byte_of(w, k));
                if (v >= 128) v = v - 256;
                r = v;
            end
            LBU: r = 32'(byte_of(w, k));
            LH: begin
                v = int'(w[16*h +: 16]);
                if (v >= 32768) v = v - 65536;
                r = v;
            end
            LHU: r = 32'(w[16*h +: 16]);
            LWL: begin
                // Bytes of w slide up to the top of the register.
                for (int i = 0; i < 4; i++) begin
                    if (i >= 3 - k) r[8*i +: 8] = byte_of(w, i - (3 - k));
                    else            r[8*i +: 8] = byte_of(rt, i);
                end
            end
            LWR: begin
                // Bytes of w slide down to the bottom of the register.
                for (int i = 0; i < 4; i++) begin
                    if (i <= 3 - k) r[8*i +: 8] = byte_of(w, i + k);
                    else            r[8*i +: 8] = byte_of(rt, i);
                end
            end
            default: r = w;
        endcase
        return r;
    endfunction

    // One command, begun and ended at a negedge. Ends on the done cycle so
    // a following call issues its start back-to-back.
    task automatic run_txn(input string tag, input memop_t o, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rt,
                           input logic [31:0] rd, input int nstall);
        logic ld;
        logic [31:0] exp_res;
        ld = model_is_load(o);
        chk(tag, "busy_at_start", 32'(busy), 32'd0);
        start = 1'b1; op = o; addr = a; store_data = sd; rt_old = rt;
        av_waitrequest = 1'b0;
        @(negedge clk);
        // Scramble command inputs to prove they were latched.
        start = 1'b0;
        op = memop_t'($urandom_range(0, 9));
        addr = $urandom; store_data = $urandom; rt_old = $urandom;
        if (model_misaligned(o, a)) begin
            chk(tag, "mis_done", 32'(done), 32'd1);
            chk(tag, "mis_err", 32'(err), 32'd1);
            chk(tag, "mis_read", 32'(av_read), 32'd0);
            chk(tag, "mis_write", 32'(av_write), 32'd0);
            chk(tag, "mis_busy", 32'(busy), 32'd0);
            $display("txn %s op=%0d addr=%h misaligned err=%0b", tag, o, a, err);
            return;
        end
        chk(tag, "busy_issue", 32'(busy), 32'd1);
        for (int i = 0; i <= nstall; i++) begin
            chk(tag, "read", 32'(av_read), 32'(ld));
            chk(tag, "write", 32'(av_write), 32'(!ld));
            chk(tag, "address", av_address, {a[31:2], 2'b00});
            chk(tag, "byteenable", 32'(av_byteenable), 32'(model_be(o, a)));
            if (!ld) chk(tag, "writedata", av_writedata, model_wd(o, sd));
            chk(tag, "done_early", 32'(done), 32'd0);
            av_waitrequest = (i < nstall);
            av_readdata = $urandom;
            @(negedge clk);
        end
        av_waitrequest = 1'b0;
        chk(tag, "read_drop", 32'(av_read), 32'd0);
        chk(tag, "write_drop", 32'(av_write), 32'd0);
        if (!ld) begin
            chk(tag, "st_done", 32'(done), 32'd1);
            chk(tag, "st_err", 32'(err), 32'd0);
            chk(tag, "st_load_held", load_result, last_load);
            $display("txn %s op=%0d addr=%h store stalls=%0d be=%b wd=%h", tag, o, a,
                     nstall, model_be(o, a), model_wd(o, sd));
            return;
        end
        chk(tag, "ld_done_early", 32'(done), 32'd0);
        av_readdata = rd;
        @(negedge clk);
        av_readdata = $urandom;
        exp_res = model_load(o, a, rd, rt);
        chk(tag, "ld_done", 32'(done), 32'd1);
        chk(tag, "ld_err", 32'(err), 32'd0);
        chk(tag, "ld_result", load_result, exp_res);
        last_load = exp_res;
        $display("txn %s op=%0d addr=%h load stalls=%0d w=%h result=%h", tag, o, a,
                 nstall, rd, load_result);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = LB; addr = '0; store_data = '0; rt_old = '0;
        av_readdata = '0; av_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", "busy", 32'(busy), 32'd0);
        chk("reset", "done", 32'(done), 32'd0);
        chk("reset", "err", 32'(err), 32'd0);
        chk("reset", "read", 32'(av_read), 32'd0);
        chk("reset", "write", 32'(av_write), 32'd0);
        chk("reset", "load_result", load_result, 32'd0);
        chk("reset", "address", av_address, 32'd0);
        chk("reset", "byteenable", 32'(av_byteenable), 32'd0);
        chk("reset", "writedata", av_writedata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_txn("lw", LW, 32'hBFC0_0010, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
        chk("lw", "const_result", load_result, 32'hDEAD_BEEF);
        run_txn("lb", LB, 32'hBFC0_0013, 32'h0, 32'h0, 32'h8011_2233, 0);
        chk("lb", "const_result", load_result, 32'hFFFF_FF80);
        run_txn("lbu", LBU, 32'hBFC0_0013, 32'h0, 32'h0, 32'h8011_2233, 0);
        chk("lbu", "const_result", load_result, 32'h0000_0080);
        run_txn("sb", SB, 32'hBFC0_0006, 32'h0000_00A5, 32'h0, 32'h0, 0);
        run_txn("lwl", LWL, 32'hBFC0_0001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0);
        chk("lwl", "const_result", load_result, 32'hCCDD_3344);
        run_txn("lwr", LWR, 32'hBFC0_0001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0);
        chk("lwr", "const_result", load_result, 32'h11AA_BBCC);
        run_txn("lw_mis", LW, 32'hBFC0_0002, 32'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        chk("lw_mis", "no_read_after", 32'(av_read), 32'd0);
        run_txn("sw_stall", SW, 32'hBFC0_0020, 32'h1234_5678, 32'h0, 32'h0, 3);
        run_txn("lh_stall", LH, 32'hBFC0_0022, 32'h0, 32'h0, 32'h9876_0000, 2);

        // Randomized traffic, back-to-back.
        for (int n = 0; n < 120; n++) begin
            run_txn($sformatf("rnd%0d", n), memop_t'($urandom_range(0, 9)), $urandom,
                    $urandom, $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a stalled store.
        @(negedge clk);
        start = 1'b1; op = SW; addr = 32'hBFC0_0040; store_data = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        av_waitrequest = 1'b1;
        @(negedge clk);
        chk("rst_mid", "write_stalled", 32'(av_write), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid", "write", 32'(av_write), 32'd0);
        chk("rst_mid", "done", 32'(done), 32'd0);
        chk("rst_mid", "busy", 32'(busy), 32'd0);
        reset = 1'b0;
        av_waitrequest = 1'b0;
        @(negedge clk);
        chk("rst_mid", "done_after", 32'(done), 32'd0);
        chk("rst_mid", "write_after", 32'(av_write), 32'd0);
        $display("txn rst_mid reset during stalled SW busy=%0b done=%0b", busy, done);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Master-side Avalon-MM load/store engine between the MIPS CPU datapath (memory stage) and the data RAM slave.
- Accepts one load/store command at a time from the CPU and issues a single word-aligned Avalon read or write.
- For stores, generates byteenable and replicates write data into lanes. For loads, extracts, sign/zero-extends or merges (LWL/LWR) the returned word.
- Honours waitrequest, flags misaligned accesses and signals completion with a one-cycle done pulse.

Parameters:
- none; data and address width fixed at 32 via size_t.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  memop_t(4)  LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW.
- addr  input  32  byte address, sampled with start.
- store_data  input  32  rt value for stores, sampled with start.
- rt_old  input  32  current rt for LWL/LWR merge, sampled with start.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  misaligned flag; valid only with done.
- load_result  output  32  load value; valid with done and held until the next done.
- av_address  output  32  Avalon address, always {addr[31:2],2'b00}.
- av_read  output  1  Avalon read.
- av_write  output  1  Avalon write.
- av_byteenable  output  4  Avalon byte lanes.
- av_writedata  output  32  Avalon write data.
- av_readdata  input  32  Avalon read data; valid the cycle after read is accepted.
- av_waitrequest  input  1  slave stall.

Behaviour:
- Reset:
  - state=IDLE.
  - av_read=0, av_write=0, done=0, err=0.
  - load_result=0, av_address=0, av_byteenable=0, av_writedata=0.
- Reset mid-operation: the next edge forces IDLE with av_read and av_write deasserted. Any in-flight readdata is discarded and no done is produced.
- All Avalon outputs are registered.
- IDLE:
  - On start=1, latch op, addr, store_data and rt_old.
  - Misaligned access goes to IDLE with done=1 and err=1 on the next cycle, and no bus cycle is issued. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - LB/LBU/SB and LWL/LWR are never misaligned.
  - Otherwise go to ISSUE, with av_read or av_write asserted in the next cycle.
- ISSUE:
  - av_read/av_write, av_address, av_byteenable and av_writedata are held stable while av_waitrequest=1.
  - When the request is accepted (waitrequest=0), the strobe drops on the next edge.
  - A store goes to IDLE with done=1 on the next cycle.
  - A load goes to CAPTURE.
- CAPTURE:
  - Sample av_readdata and compute the result.
  - Register load_result, set done=1 and go to IDLE.
- Latency with no stall:
  - Store: start@0, write@1, done@2.
  - Load: start@0, read@1, data@2, done@3.
  - Each waitrequest cycle adds one cycle.
- start while busy=1 is ignored. The done cycle is in IDLE, so back-to-back starts are allowed from the done cycle.
- Byte lanes are little-endian; k = addr[1:0].
- Store byteenable and writedata:
  - SB: byteenable = 1<<k; writedata = {4{store_data[7:0]}}.
  - SH: byteenable = k[1] ? 4'b1100 : 4'b0011; writedata = {2{store_data[15:0]}}.
  - SW: byteenable = 4'b1111; writedata = store_data.
- All loads use byteenable 4'b1111.
- Load extraction, with w = captured av_readdata:
  - LB/LBU: byte w[8k+7:8k], sign- or zero-extended.
  - LH/LHU: half w[16*k[1]+15:16*k[1]], sign- or zero-extended.
  - LW: w.
  - LWL: (w << 8*(3-k)) | (rt_old & (32'hFFFFFFFF >> 8*(k+1))). k=3 gives w.
  - LWR: (w >> 8*k) | (rt_old & ~(32'hFFFFFFFF >> 8*k)). k=0 gives w.
- err is 0 on every done for an aligned op.

Decomposition:
- Shared package codes gains:
  - memop_t enum (4 bits, values above);
  - memstate_t enum {IDLE, ISSUE, CAPTURE}.
- codes already provides size_t.
- One combinational sub-module, mem_load_align. Inputs: op, k, w, rt_old. Output: the 32-bit load result. It is reused by later cache/bus work.

Test Plan:
- LW, addr=0xBFC00010, slave returns 0xDEADBEEF, no stall -> av_read high for 1 cycle at 0xBFC00010, byteenable 1111; done at cycle 3 with load_result=0xDEADBEEF, err=0.
- LB/LBU, addr=0xBFC00013, readdata=0x80112233 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SB, addr=0xBFC00006, store_data=0x000000A5 -> byteenable 0100, writedata 0xA5A5A5A5, address 0xBFC00004; done at cycle 2.
- LWL/LWR, rt_old=0x11223344, readdata=0xAABBCCDD:
  - LWL k=1 -> 0xCCDD3344.
  - LWR k=1 -> 0x11AABBCC.
- Misaligned LW at 0xBFC00002 -> no av_read ever asserted; done=err=1 next cycle.
- Stall and reset:
  - SW with waitrequest held 3 cycles -> write, address and data stable all 4 cycles, done 1 cycle after release.
  - Reset asserted during that stall -> av_write=0 next cycle, no done, busy=0.
